// File: rtl/mux_alu_if.sv
// Bus between the ALU functional units and the result-select stage:
// operand results and select code in, registered result and status flags out.
interface mux_alu_if #(
  parameter int WIDTH = 32
);
  logic             EN;
  logic [2:0]       ALUSEL;
  logic [WIDTH-1:0] AND;
  logic [WIDTH-1:0] OR;
  logic [WIDTH-1:0] RES;
  logic [WIDTH-1:0] SUM;
  logic [WIDTH-1:0] LLS;
  logic [WIDTH-1:0] ASR;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;
  logic             Neg;
  logic             SelErr;

  modport master (
    output EN, ALUSEL, AND, OR, RES, SUM, LLS, ASR,
    input  ALUOut, Zero, Neg, SelErr
  );

  modport slave (
    input  EN, ALUSEL, AND, OR, RES, SUM, LLS, ASR,
    output ALUOut, Zero, Neg, SelErr
  );
endinterface

// File: rtl/mux_alu.sv
// Result-select stage of the ALU: picks one of six precomputed results by ALUSEL,
// registers it together with zero, negative and illegal-select flags.
module mux_alu #(
  parameter int WIDTH = 32
) (
  input logic       CLK,
  input logic       RST,
  mux_alu_if.slave  bus
);
  localparam int NOPS = 6;

  logic [WIDTH-1:0] operand [NOPS];
  logic [WIDTH-1:0] masked [NOPS];
  logic [NOPS-1:0]  onehot;
  logic [WIDTH-1:0] sel_value_next;
  logic             sel_err_next;
  logic             zero_next;
  logic             neg_next;

  logic [WIDTH-1:0] aluout_reg;
  logic             zero_reg;
  logic             neg_reg;
  logic             sel_err_reg;

  // Operand order matches the select code: index == ALUSEL.
  assign operand[0] = bus.AND;
  assign operand[1] = bus.OR;
  assign operand[2] = bus.RES;
  assign operand[3] = bus.SUM;
  assign operand[4] = bus.LLS;
  assign operand[5] = bus.ASR;

  always_comb begin
    onehot       = '0;
    sel_err_next = 1'b0;
    case (bus.ALUSEL)
      3'b000:  onehot[0] = 1'b1;
      3'b001:  onehot[1] = 1'b1;
      3'b010:  onehot[2] = 1'b1;
      3'b011:  onehot[3] = 1'b1;
      3'b100:  onehot[4] = 1'b1;
      3'b101:  onehot[5] = 1'b1;
      default: sel_err_next = 1'b1;
    endcase
  end

  // AND-OR mux: an illegal code leaves every mask clear, so the result is zero.
  genvar gi;
  generate
    for (gi = 0; gi < NOPS; gi++) begin : g_mask
      assign masked[gi] = operand[gi] & {WIDTH{onehot[gi]}};
    end
  endgenerate

  always_comb begin
    sel_value_next = '0;
    for (int i = 0; i < NOPS; i++) begin
      sel_value_next = sel_value_next | masked[i];
    end
  end

  assign zero_next = ~|sel_value_next;
  assign neg_next  = sel_value_next[WIDTH-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      aluout_reg  <= '0;
      zero_reg    <= 1'b1;
      neg_reg     <= 1'b0;
      sel_err_reg <= 1'b0;
    end else if (bus.EN) begin
      aluout_reg  <= sel_value_next;
      zero_reg    <= zero_next;
      neg_reg     <= neg_next;
      sel_err_reg <= sel_err_next;
    end
  end

  assign bus.ALUOut = aluout_reg;
  assign bus.Zero   = zero_reg;
  assign bus.Neg    = neg_reg;
  assign bus.SelErr = sel_err_reg;
endmodule

// File: tb/tb_mux_alu.sv
// Self-checking bench for mux_alu: directed vector table, a mid-stream reset
// sequence, and randomized traffic against a behavioural model.
module tb_mux_alu;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST;
  always #10 CLK = ~CLK;

  mux_alu_if #(.WIDTH(W)) bus ();
  mux_alu #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic         rst;
    logic         en;
    logic [2:0]   sel;
    logic [W-1:0] op [6];
    logic [W-1:0] exp_out;
    logic         exp_zero;
    logic         exp_neg;
    logic         exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl [19];

  // behavioural model state
  logic [W-1:0] m_out;
  logic         m_zero, m_neg, m_err;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] sel,
                       input logic [W-1:0] op [6]);
    RST        = rst;
    bus.EN     = en;
    bus.ALUSEL = sel;
    bus.AND    = op[0];
    bus.OR     = op[1];
    bus.RES    = op[2];
    bus.SUM    = op[3];
    bus.LLS    = op[4];
    bus.ASR    = op[5];
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] eo,
                           input logic ez, input logic en_, input logic ee);
    chk({tag, ".ALUOut"}, bus.ALUOut, eo);
    chk({tag, ".Zero"},   {31'b0, bus.Zero},   {31'b0, ez});
    chk({tag, ".Neg"},    {31'b0, bus.Neg},    {31'b0, en_});
    chk({tag, ".SelErr"}, {31'b0, bus.SelErr}, {31'b0, ee});
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input logic [2:0] sel,
                              input logic [W-1:0] r, input logic [W-1:0] s,
                              input logic [W-1:0] eo, input logic ez,
                              input logic en_, input logic ee);
    vec_t v;
    v.rst = rst; v.en = en; v.sel = sel;
    v.op[0] = 23; v.op[1] = 1; v.op[2] = r; v.op[3] = s; v.op[4] = 5; v.op[5] = 100;
    v.exp_out = eo; v.exp_zero = ez; v.exp_neg = en_; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    logic [W-1:0] ops [6];
    logic [2:0]   sel;
    logic         rst, en;
    logic [W-1:0] picked;

    tbl[0]  = mk(1, 1, 3'd0, 2, 10, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 3'd3, 2, 10, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 3'd0, 2, 10, 23, 0, 0, 0);
    tbl[3]  = mk(0, 1, 3'd1, 2, 10, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 3'd2, 2, 10, 2, 0, 0, 0);
    tbl[5]  = mk(0, 1, 3'd3, 2, 10, 10, 0, 0, 0);
    tbl[6]  = mk(0, 1, 3'd4, 2, 10, 5, 0, 0, 0);
    tbl[7]  = mk(0, 1, 3'd5, 2, 10, 100, 0, 0, 0);
    tbl[8]  = mk(0, 1, 3'd6, 2, 10, 0, 1, 0, 1);
    tbl[9]  = mk(0, 1, 3'd7, 2, 10, 0, 1, 0, 1);
    tbl[10] = mk(0, 1, 3'd3, 2, 10, 10, 0, 0, 0);
    tbl[11] = mk(0, 1, 3'd2, 32'h8000_0000, 10, 32'h8000_0000, 0, 1, 0);
    tbl[12] = mk(0, 1, 3'd2, 0, 10, 0, 1, 0, 0);
    tbl[13] = mk(0, 1, 3'd3, 2, 10, 10, 0, 0, 0);
    tbl[14] = mk(0, 0, 3'd5, 2, 7, 10, 0, 0, 0);
    tbl[15] = mk(0, 0, 3'd5, 2, 7, 10, 0, 0, 0);
    tbl[16] = mk(0, 1, 3'd5, 2, 7, 100, 0, 0, 0);
    tbl[17] = mk(1, 1, 3'd0, 2, 10, 0, 1, 0, 0);
    tbl[18] = mk(0, 1, 3'd0, 2, 10, 23, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].op);
      @(posedge CLK); #1;
      $display("vec %0d rst=%0b en=%0b sel=%0d -> out=%h Z=%0b N=%0b E=%0b",
               i, tbl[i].rst, tbl[i].en, tbl[i].sel, bus.ALUOut, bus.Zero, bus.Neg, bus.SelErr);
      check_all($sformatf("vec%0d", i), tbl[i].exp_out, tbl[i].exp_zero,
                tbl[i].exp_neg, tbl[i].exp_err);
    end

    // Mid-stream reset: a pending negative selection is discarded, and the
    // first load after reset waits for EN.
    ops[0] = 32'h1; ops[1] = 32'h2; ops[2] = 32'h3;
    ops[3] = 32'h4; ops[4] = 32'h5; ops[5] = 32'hF000_0000;
    drive(0, 1, 3'd5, ops); @(posedge CLK); #1;
    $display("seq load  out=%h", bus.ALUOut);
    check_all("seq_load", 32'hF000_0000, 0, 1, 0);
    drive(1, 1, 3'd6, ops); @(posedge CLK); #1;
    $display("seq reset out=%h", bus.ALUOut);
    check_all("seq_rst", 0, 1, 0, 0);
    drive(0, 0, 3'd4, ops); @(posedge CLK); #1;
    $display("seq hold  out=%h", bus.ALUOut);
    check_all("seq_hold", 0, 1, 0, 0);
    drive(0, 1, 3'd4, ops); @(posedge CLK); #1;
    $display("seq load2 out=%h", bus.ALUOut);
    check_all("seq_load2", 32'h5, 0, 0, 0);

    m_out = 32'h5; m_zero = 0; m_neg = 0; m_err = 0;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) != 0);
      sel = 3'($urandom_range(0, 7));
      for (int k = 0; k < 6; k++) begin
        case ($urandom_range(0, 7))
          0:       ops[k] = '0;
          1:       ops[k] = 32'h8000_0000;
          default: ops[k] = $urandom;
        endcase
      end
      drive(rst, en, sel, ops);
      // Model: an undefined code selects nothing, so the result is zero.
      picked = (sel < 3'd6) ? ops[sel] : '0;
      if (rst) begin
        m_out = '0; m_zero = 1; m_neg = 0; m_err = 0;
      end else if (en) begin
        m_out  = picked;
        m_zero = (picked == 0);
        m_neg  = (picked >= 32'h8000_0000);
        m_err  = (sel > 3'd5);
      end
      @(posedge CLK); #1;
      $display("rnd %0d rst=%0b en=%0b sel=%0d -> out=%h Z=%0b N=%0b E=%0b",
               n, rst, en, sel, bus.ALUOut, bus.Zero, bus.Neg, bus.SelErr);
      check_all($sformatf("rnd%0d", n), m_out, m_zero, m_neg, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
